// File: rtl/accel_tilt_display.sv
// accel_tilt_display: moving-average consumer for signed accelerometer samples.
// Averages the last 2^AVG_LOG2 samples, converts the magnitude to BCD with a
// bit-serial double-dabble, and drives six active-low 7-segment digits plus a
// one-hot 10-LED tilt bubble. Upstream is throttled via sample_ready.
module accel_tilt_display #(
    parameter int DATA_W    = 16,
    parameter int AVG_LOG2  = 3,
    parameter int LED_SHIFT = 5
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic [6:0]        hex_0_export,
    output logic [6:0]        hex_1_export,
    output logic [6:0]        hex_2_export,
    output logic [6:0]        hex_3_export,
    output logic [6:0]        hex_4_export,
    output logic [6:0]        hex_5_export,
    output logic [9:0]        led_external_connection_export
);

    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [9:0] LED_CENTER = 10'b0000100000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CONVERT = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t state_r, next_state_s;

    logic signed [DATA_W-1:0] hist_r [DEPTH];
    logic signed [SUM_W-1:0]  sum_r;
    logic [AVG_LOG2-1:0]      wptr_r;
    logic                     sign_r;
    logic [DATA_W-1:0]        mag_r;
    logic [19:0]              bcd_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [3:0]               led_idx_r;

    logic signed [DATA_W-1:0] avg_s;
    logic [DATA_W-1:0]        mag_s;
    logic signed [DATA_W-1:0] led_step_s;
    logic signed [DATA_W:0]   led_pos_s;
    logic [3:0]               led_idx_s;
    logic [6:0]               seg_s [6];
    logic                     blank_s [1:4];

    // Active-low segment pattern for one decimal digit (g..a in bits 6..0).
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
        logic [19:0] r;
        r = bcd;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Average, magnitude and clamped LED index derived from the running sum.
    always_comb begin
        avg_s      = sum_r[SUM_W-1:AVG_LOG2];
        mag_s      = avg_s[DATA_W-1] ? DATA_W'(-avg_s) : DATA_W'(avg_s);
        led_step_s = avg_s >>> LED_SHIFT;
        led_pos_s  = {led_step_s[DATA_W-1], led_step_s} + (DATA_W+1)'(5);
        if (led_pos_s < 0) begin
            led_idx_s = 4'd0;
        end else if (led_pos_s > (DATA_W+1)'(9)) begin
            led_idx_s = 4'd9;
        end else begin
            led_idx_s = led_pos_s[3:0];
        end
    end

    // Segment patterns with leading-zero blanking from the finished BCD value.
    always_comb begin
        blank_s[4] = (bcd_r[19:16] == 4'd0);
        blank_s[3] = blank_s[4] && (bcd_r[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (bcd_r[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (bcd_r[7:4] == 4'd0);
        seg_s[0]   = seg7(bcd_r[3:0]);
        for (int i = 1; i < 5; i++) begin
            if (blank_s[i]) begin
                seg_s[i] = SEG_BLANK;
            end else begin
                seg_s[i] = seg7(bcd_r[i*4 +: 4]);
            end
        end
        if (sign_r) begin
            seg_s[5] = SEG_MINUS;
        end else begin
            seg_s[5] = SEG_BLANK;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (sample_valid) begin
                    next_state_s = ACCUM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM:   next_state_s = CONVERT;
            CONVERT: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = UPDATE;
                end else begin
                    next_state_s = CONVERT;
                end
            end
            UPDATE:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: accept only when idle.
    always_comb begin
        sample_ready = (state_r == IDLE);
        busy         = (state_r != IDLE);
    end

    // Datapath: history/sum on transfer, latch magnitude, serial BCD conversion.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_r[i] <= {DATA_W{1'b0}};
            end
            sum_r     <= {SUM_W{1'b0}};
            wptr_r    <= {AVG_LOG2{1'b0}};
            sign_r    <= 1'b0;
            mag_r     <= {DATA_W{1'b0}};
            bcd_r     <= 20'd0;
            cnt_r     <= {CNT_W{1'b0}};
            led_idx_r <= 4'd5;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sample_valid) begin
                        sum_r <= sum_r
                                 - {{AVG_LOG2{hist_r[wptr_r][DATA_W-1]}}, hist_r[wptr_r]}
                                 + {{AVG_LOG2{sample_data[DATA_W-1]}}, sample_data};
                        hist_r[wptr_r] <= sample_data;
                        wptr_r         <= wptr_r + AVG_LOG2'(1);
                    end
                end
                ACCUM: begin
                    sign_r    <= avg_s[DATA_W-1];
                    mag_r     <= mag_s;
                    led_idx_r <= led_idx_s;
                    bcd_r     <= 20'd0;
                    cnt_r     <= {CNT_W{1'b0}};
                end
                CONVERT: begin
                    bcd_r <= {dabble_adjust(bcd_r)[18:0], mag_r[DATA_W-1]};
                    mag_r <= mag_r << 1;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Display registers: all digits and LEDs change together at UPDATE.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hex_0_export                   <= SEG_ZERO;
            hex_1_export                   <= SEG_BLANK;
            hex_2_export                   <= SEG_BLANK;
            hex_3_export                   <= SEG_BLANK;
            hex_4_export                   <= SEG_BLANK;
            hex_5_export                   <= SEG_BLANK;
            led_external_connection_export <= LED_CENTER;
        end else if (state_r == UPDATE) begin
            hex_0_export                   <= seg_s[0];
            hex_1_export                   <= seg_s[1];
            hex_2_export                   <= seg_s[2];
            hex_3_export                   <= seg_s[3];
            hex_4_export                   <= seg_s[4];
            hex_5_export                   <= seg_s[5];
            led_external_connection_export <= 10'd1 << led_idx_r;
        end else begin
            led_external_connection_export <= led_external_connection_export;
        end
    end

endmodule
